heap_sort_arbiter: RTL

HEAP_SORT_ARBITER -- requirements
Module: heap_sort_arbiter

---
 rtl/heap_sort_pkg.sv | 26 ++
 rtl/heap_sort_rr_arb2.sv | 32 +++
 rtl/heap_sort_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/heap_sort_pkg.sv
// Shared sizing, FSM state type and round-robin helper for the heap-sort arbiter.
package heap_sort_pkg;

  localparam int unsigned ELEM_W    = 23;
  localparam int unsigned ELEM_N    = 7;
  localparam int unsigned VEC_W_DEF = ELEM_W * ELEM_N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  // One-hot grant for two requesters; on a tie the one not granted last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    if (req == 2'b11) begin
      g = last ? 2'b01 : 2'b10;
    end else begin
      g = req;
    end
    return g;
  endfunction

endpackage

// File: rtl/heap_sort_rr_arb2.sv
// Two-way round-robin grant; history resets so requester 0 wins the first tie.
module heap_sort_rr_arb2
  import heap_sort_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o    = rr_pick(req_i, last_q);
    gnt_id_o = gnt_o[1];
    last_d   = last_q;
    if (en_i && (req_i != 2'b00)) begin
      last_d = gnt_id_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/heap_sort_arbiter.sv
// Round-robin front end sharing one heap-sort engine between two requesters.
// Optional watchdog abort in WAIT: define HEAP_SORT_ARB_TIMEOUT_EN.
module heap_sort_arbiter
  import heap_sort_pkg::*;
#(
  parameter int unsigned VEC_W       = VEC_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  input  logic [VEC_W-1:0] req0_vec_i,
  input  logic [VEC_W-1:0] req1_vec_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  output logic             resp0_valid_o,
  output logic             resp1_valid_o,
  input  logic             resp0_ready_i,
  input  logic             resp1_ready_i,
  output logic [VEC_W-1:0] resp_vec_o,
  output logic             resp_err_o,
  output logic             eng_start_o,
  output logic [VEC_W-1:0] eng_vec_o,
  input  logic             eng_done_i,
  input  logic [VEC_W-1:0] eng_vec_i,
  output logic             busy_o
);

  arb_state_e       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] res_q, res_d;
  logic             id_q, id_d;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             arb_en;
  logic             resp_take;
  logic             wd_fire;

  assign arb_en = (state_q == ST_IDLE);

  heap_sort_rr_arb2 u_arb (
    .clk_i    (system1000),
    .rst_i    (system1000_rst),
    .req_i    ({req1_valid_i, req0_valid_i}),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign resp_take = id_q ? resp1_ready_i : resp0_ready_i;

`ifdef HEAP_SORT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign wd_fire = (state_q == ST_WAIT) && !eng_done_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == ST_WAIT) begin
      if (eng_done_i) begin
        err_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wd_fire) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err_o = err_q;
`else
  logic timeout_unused;

  assign timeout_unused = (TIMEOUT_CYC != 0);
  assign wd_fire        = 1'b0;
  assign resp_err_o     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    id_d    = id_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          vec_d   = gnt_id ? req1_vec_i : req0_vec_i;
          id_d    = gnt_id;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done_i) begin
          res_d   = eng_vec_i;
          state_d = ST_RESP;
        end else if (wd_fire) begin
          res_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_take) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  // Grant is combinational in IDLE, so mask it while reset is held.
  assign req0_ready_o  = arb_en && gnt[0] && !system1000_rst;
  assign req1_ready_o  = arb_en && gnt[1] && !system1000_rst;
  assign resp0_valid_o = (state_q == ST_RESP) && !id_q;
  assign resp1_valid_o = (state_q == ST_RESP) && id_q;
  assign eng_start_o   = (state_q == ST_ISSUE);
  assign eng_vec_o     = vec_q;
  assign resp_vec_o    = res_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
